// File: rtl/div32x32_if.sv
// div32x32 operand/result bus: start request, operands, busy and registered results.
// Latency: none (wiring only); results arrive 34 edges after the start edge.
// Backpressure: none; requester watches busy, divider ignores start outside IDLE.
interface div32x32_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  // Requester side: issues operands and start, observes busy and results.
  modport master (
    output start, dividend, divisor,
    input  busy, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32x32.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock (IDLE/CALC/FIN).
// Latency: 34 edges start->results (2 edges with DIV32_EARLY_EXIT_EN when divisor==0 or dividend<divisor).
// Backpressure: start is only sampled in IDLE; busy is combinational (start in IDLE, 1 in CALC).
module div32x32 (
  input  logic         clk,
  input  logic         reset,
  div32x32_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] dvd;   // shifting dividend; accumulates the quotient from bit 0 upward
  logic [31:0] dvs;
  logic [31:0] rem;   // partial remainder
  logic [4:0]  cnt;
  logic [32:0] trial;
  logic        early;

  // Trial subtraction of the divisor from the shifted partial remainder; bit 32 is the borrow.
  assign trial = {rem, dvd[31]} - {1'b0, dvs};

  // Short-circuit condition: the quotient is known without iterating.
`ifdef DIV32_EARLY_EXIT_EN
  assign early = (bus.divisor == 32'd0) || (bus.dividend < bus.divisor);
`else
  assign early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and busy decode; busy is forced low while reset is high.
  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = bus.start & ~reset;
        if (bus.start) state_nxt = early ? FIN : CALC;
      end
      CALC: begin
        bus.busy = ~reset;
        if (cnt == 5'd31) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, restoring iteration and result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd             <= 32'd0;
      dvs             <= 32'd0;
      rem             <= 32'd0;
      cnt             <= 5'd0;
      bus.quotient    <= 32'd0;
      bus.remainder   <= 32'd0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvs <= bus.divisor;
            cnt <= 5'd0;
            if (early) begin
              // Preload the final answer so FIN writes it back unchanged.
              dvd <= (bus.divisor == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
              rem <= bus.dividend;
            end else begin
              dvd <= bus.dividend;
              rem <= 32'd0;
            end
          end
        end
        CALC: begin
          dvd <= {dvd[30:0], ~trial[32]};
          rem <= trial[32] ? {rem[30:0], dvd[31]} : trial[31:0];
          cnt <= cnt + 5'd1;
        end
        FIN: begin
          bus.quotient    <= dvd;
          bus.remainder   <= rem;
          bus.div_by_zero <= (dvs == 32'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div32x32.md
# div32x32

- Sequential 32-bit unsigned integer divider, radix-2 restoring, one quotient bit per clock.
- Companion to the 32x32 multiplier: it performs the inverse operation and uses the same start/busy handshake, so the arithmetic unit can treat both blocks uniformly.
- Contains its own FSM, iteration counter, operand registers and result registers.

## Interface
Parameters:
- none; dividend, divisor, quotient and remainder are fixed at 32 bits.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  32  numerator, captured on the start edge
- divisor  input  32  denominator, captured on the start edge
- busy  output  1  division in progress
- quotient  output  32  registered result, held until the next completion
- remainder  output  32  registered result, held until the next completion
- div_by_zero  output  1  registered flag, set when the last captured divisor was 0

## Operation
- States: IDLE, CALC, FIN.
- IDLE:
  - busy = start, combinationally.
  - On an edge with start=1: capture dividend and divisor; clear the partial remainder; set iteration counter = 0; go to CALC.
  - On an edge with start=0: stay in IDLE.
- CALC, one iteration per edge:
  - trial = {rem[31:0], dvd[31]} - {1'b0, dvs} (33-bit).
  - If trial[32]=0: rem <= trial[31:0]; quotient bit = 1.
  - Else: rem <= {rem[30:0], dvd[31]}; quotient bit = 0.
  - dvd shifts left by one; the quotient bit enters dvd[0], so dvd accumulates the quotient.
  - Counter increments. After the 32nd iteration (counter = 31 on that edge), go to FIN.
  - busy = 1. start is ignored.
- FIN:
  - busy = 0. start is ignored.
  - On the edge: quotient <= dvd, remainder <= rem, div_by_zero <= (dvs == 0); go to IDLE.
- Divide by zero needs no special path. The algorithm naturally gives quotient = 32'hFFFF_FFFF and remainder = dividend. div_by_zero is the only distinguishing signal.
- Result registers change only on the FIN edge and on reset.
- Reset, from any state including mid-CALC:
  - Next state is IDLE.
  - quotient, remainder, div_by_zero and the internal registers are cleared to 0.
  - busy = 0 for every cycle in which reset is high, regardless of start.
  - An aborted division produces no result update.

## Timing
- Cycle 0: IDLE with start=1; busy=1 in the same cycle.
- Cycles 1–32: CALC; busy=1.
- Cycle 33: FIN; busy=0.
- Results are valid from cycle 34. Total latency from the start edge to valid results is 34 edges.
- Back-to-back operation: start may be high in cycle 34 (IDLE). Throughput is one division per 34 cycles.
- start held high continuously: it is re-sampled only in IDLE, so divisions repeat every 34 cycles.
- All outputs except busy are registered. busy is combinational from the state and from start (only start in IDLE).

## Configuration
- DIV32_EARLY_EXIT_EN
- Defined: on the start edge, if divisor == 0 or dividend < divisor, the block goes IDLE → FIN directly and skips CALC.
  - FIN writes quotient = 32'hFFFF_FFFF if divisor is 0, otherwise 0.
  - FIN writes remainder = dividend.
  - div_by_zero is written as normal.
  - busy = 1 only in cycle 0; results are valid in cycle 2.
- Undefined: every division takes the full 32 CALC cycles, with results bit-identical to the defined case.

## Test plan
- Basic: dividend=100, divisor=7, start pulsed one cycle → busy high for cycles 0–32, low in 33; from cycle 34, quotient=14, remainder=2, div_by_zero=0.
- Extremes: dividend=32'hFFFF_FFFF, divisor=1 → quotient=32'hFFFF_FFFF, remainder=0. Then dividend=32'hFFFF_FFFF, divisor=32'hFFFF_FFFF → quotient=1, remainder=0.
- Divide by zero: dividend=32'h1234_5678, divisor=0 → quotient=32'hFFFF_FFFF, remainder=32'h1234_5678, div_by_zero=1. A following 10/3 → 3, 1, div_by_zero=0.
- Handshake:
  - start held high continuously → completions every 34 cycles.
  - Operand inputs changed during CALC → result unaffected.
  - start pulsed in FIN → ignored.
- Reset mid-op: assert reset in cycle 15 of 1000/10 → next cycle state IDLE, busy=0, quotient=0, remainder=0. A fresh 1000/10 then yields 100, 0.
- With DIV32_EARLY_EXIT_EN: 5/9 → busy only in cycle 0; quotient=0, remainder=5 in cycle 2. 9/5 still takes 34 cycles → 1, 4.
